// File: rtl/bist_pkg.sv
// March C- BIST shared definitions: element table, FSM encoding, element index width.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package bist_pkg;

   localparam int ELEM_W = 3;

   // Element index used as the "all ops issued" marker after E5.
   localparam logic [ELEM_W-1:0] ELEM_END = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Element table, bit i describes March element i (bits 6/7 unused, kept 0).
   //   E0 up(wD)  E1 up(rD,w~D)  E2 up(r~D,wD)  E3 dn(rD,w~D)  E4 dn(r~D,wD)  E5 up(rD)
   localparam logic [7:0] ELEM_DN     = 8'b0001_1000;  // descending address order
   localparam logic [7:0] ELEM_HAS_RD = 8'b0011_1110;  // element contains a read op
   localparam logic [7:0] ELEM_HAS_WR = 8'b0001_1111;  // element contains a write op
   localparam logic [7:0] ELEM_RD_INV = 8'b0001_0100;  // read expects inverse background
   localparam logic [7:0] ELEM_WR_INV = 8'b0000_1010;  // write uses inverse background

   // Two-op elements spend two cycles per address: read first, then write.
   function automatic logic elem_two_op(input logic [ELEM_W-1:0] e);
      return ELEM_HAS_RD[e] & ELEM_HAS_WR[e];
   endfunction

endpackage

// File: rtl/bist_addr_gen.sv
// Loadable up/down address counter with terminal-count flag for the March sequencer.
// Latency: load/step visible on cnt one clk after ld/en; tc is combinational from cnt.
// Backpressure: none; holds its value whenever ld and en are both low.
//   ports: clk, rst (async high), ld/ld_val (load), en (step), dn (direction),
//          cnt (current address), tc (cnt is the last address for direction dn)
module bist_addr_gen #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld,
   input  logic [ADDR_W-1:0] ld_val,
   input  logic              en,
   input  logic              dn,
   output logic [ADDR_W-1:0] cnt,
   output logic              tc
);

   localparam logic [ADDR_W-1:0] ONE = 1;

   logic [ADDR_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (ld) begin
         cnt_d = ld_val;
      end else if (en) begin
         cnt_d = dn ? (cnt_q - ONE) : (cnt_q + ONE);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;
   assign tc  = dn ? (cnt_q == '0) : (cnt_q == '1);

endmodule

// File: rtl/bist_march_ctrl.sv
// March C- BIST controller for a single-port synchronous SRAM; reports first failing read.
// Latency: first op one clk after start is sampled; done 10*DEPTH+2 clks after start.
// Backpressure: none; start ignored while busy, one SRAM op issued every RUN cycle.
//   ports: clk, rst (async high), start (pulse), mem_rdata (1 clk after mem_re),
//          mem_addr/mem_wdata/mem_we/mem_re (registered SRAM port), busy, done,
//          fail (sticky), fail_addr/fail_elem/fail_data (first mismatch capture)
module bist_march_ctrl
   import bist_pkg::*;
#(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 4,
   parameter int BG           = 0,
   parameter bit STOP_ON_FAIL = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   output logic              busy,
   output logic              done,
   output logic              fail,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [ELEM_W-1:0] fail_elem,
   output logic [DATA_W-1:0] fail_data
);

   localparam logic BG_BIT = BG[0];
   localparam logic [DATA_W-1:0] BG_DAT = {DATA_W{BG_BIT}};

   state_t            state_q, state_d;
   logic [ELEM_W-1:0] elem_q, elem_d, elem_nxt;
   logic              phase_q, phase_d;       // 0: first op of address, 1: write of two-op element

   logic [ADDR_W-1:0] addr_cnt, addr_ld_val;
   logic              addr_tc, addr_ld, addr_en;

   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_we_q, mem_we_d, mem_re_q, mem_re_d;
   logic [DATA_W-1:0] rd_exp_q, rd_exp_d;     // expected data travelling with mem_re
   logic [ELEM_W-1:0] rd_elem_q, rd_elem_d;

   logic              cmp_vld_q, cmp_vld_d;   // rdata for this read is on mem_rdata now
   logic [DATA_W-1:0] cmp_exp_q, cmp_exp_d;
   logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
   logic [ELEM_W-1:0] cmp_elem_q, cmp_elem_d;

   logic              fail_q, fail_d;
   logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
   logic [ELEM_W-1:0] fail_elem_q, fail_elem_d;
   logic [DATA_W-1:0] fail_data_q, fail_data_d;

   logic start_ok, cmp_hit, abort, issue, op_rd, last_op;

   assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   // A compare left in flight by an abort must not fire once DONE is reached.
   assign cmp_hit  = cmp_vld_q && ((state_q == ST_RUN) || (state_q == ST_FLUSH))
                     && (mem_rdata != cmp_exp_q);
   assign abort    = STOP_ON_FAIL && cmp_hit;
   assign issue    = (state_q == ST_RUN) && (elem_q != ELEM_END) && !abort;
   assign op_rd    = ELEM_HAS_RD[elem_q] && !phase_q;
   assign last_op  = !(elem_two_op(elem_q) && !phase_q);
   assign elem_nxt = elem_q + 3'd1;

   bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
      .clk    (clk),
      .rst    (rst),
      .ld     (addr_ld),
      .ld_val (addr_ld_val),
      .en     (addr_en),
      .dn     (ELEM_DN[elem_q]),
      .cnt    (addr_cnt),
      .tc     (addr_tc)
   );

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: if (start_ok) state_d = ST_RUN;
         ST_RUN: begin
            if (abort)                     state_d = ST_DONE;
            else if (elem_q == ELEM_END)   state_d = ST_FLUSH;  // last op already on the port
         end
         ST_FLUSH:                         state_d = ST_DONE;   // final compare happens here
         default:                          state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: op sequencer, compare pipeline, capture
   always_comb begin
      elem_d      = elem_q;
      phase_d     = phase_q;
      addr_ld     = 1'b0;
      addr_en     = 1'b0;
      addr_ld_val = '0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      mem_we_d    = 1'b0;
      mem_re_d    = 1'b0;
      rd_exp_d    = '0;
      rd_elem_d   = '0;

      if (start_ok) begin
         elem_d  = '0;
         phase_d = 1'b0;
         addr_ld = 1'b1;
      end else if (issue) begin
         mem_addr_d = addr_cnt;
         mem_re_d   = op_rd;
         mem_we_d   = !op_rd;
         if (op_rd) begin
            rd_exp_d  = BG_DAT ^ {DATA_W{ELEM_RD_INV[elem_q]}};
            rd_elem_d = elem_q;
         end else begin
            mem_wdata_d = BG_DAT ^ {DATA_W{ELEM_WR_INV[elem_q]}};
         end
         if (!last_op) begin
            phase_d = 1'b1;
         end else begin
            phase_d = 1'b0;
            if (addr_tc) begin
               // Wrap straight to the next element's start address, no idle cycle.
               elem_d      = elem_nxt;
               addr_ld     = 1'b1;
               addr_ld_val = ELEM_DN[elem_nxt] ? '1 : '0;
            end else begin
               addr_en = 1'b1;
            end
         end
      end

      cmp_vld_d  = mem_re_q;
      cmp_exp_d  = rd_exp_q;
      cmp_addr_d = mem_addr_q;
      cmp_elem_d = rd_elem_q;

      fail_d      = fail_q;
      fail_addr_d = fail_addr_q;
      fail_elem_d = fail_elem_q;
      fail_data_d = fail_data_q;
      if (start_ok) begin
         fail_d      = 1'b0;
         fail_addr_d = '0;
         fail_elem_d = '0;
         fail_data_d = '0;
      end else if (cmp_hit) begin
         fail_d = 1'b1;
         if (!fail_q) begin
            fail_addr_d = cmp_addr_q;
            fail_elem_d = cmp_elem_q;
            fail_data_d = mem_rdata;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         elem_q      <= '0;
         phase_q     <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         rd_exp_q    <= '0;
         rd_elem_q   <= '0;
         cmp_vld_q   <= 1'b0;
         cmp_exp_q   <= '0;
         cmp_addr_q  <= '0;
         cmp_elem_q  <= '0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_elem_q <= '0;
         fail_data_q <= '0;
      end else begin
         elem_q      <= elem_d;
         phase_q     <= phase_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
         mem_re_q    <= mem_re_d;
         rd_exp_q    <= rd_exp_d;
         rd_elem_q   <= rd_elem_d;
         cmp_vld_q   <= cmp_vld_d;
         cmp_exp_q   <= cmp_exp_d;
         cmp_addr_q  <= cmp_addr_d;
         cmp_elem_q  <= cmp_elem_d;
         fail_q      <= fail_d;
         fail_addr_q <= fail_addr_d;
         fail_elem_q <= fail_elem_d;
         fail_data_q <= fail_data_d;
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_we    = mem_we_q;
   assign mem_re    = mem_re_q;
   assign busy      = (state_q == ST_RUN) || (state_q == ST_FLUSH);
   assign done      = (state_q == ST_DONE);
   assign fail      = fail_q;
   assign fail_addr = fail_addr_q;
   assign fail_elem = fail_elem_q;
   assign fail_data = fail_data_q;

endmodule

// File: tb/tb_bist_march_ctrl.sv
// Directed bench for bist_march_ctrl: two 16x4 instances with SRAM models and fault hooks.
// Instance a: BG=0, STOP_ON_FAIL=1 (stuck-at bit0 at addr 5). Instance b: BG=1,
// STOP_ON_FAIL=0 (write to addr 9 inverts addr 3).
module tb_bist_march_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- instance a ----------------
   logic       a_start = 1'b0;
   logic [3:0] a_rdata = 4'h0;
   logic [3:0] a_addr, a_wdata, a_fail_addr, a_fail_data;
   logic [2:0] a_fail_elem;
   logic       a_we, a_re, a_busy, a_done, a_fail;
   logic [3:0] a_mem [16];
   logic       a_sa_en = 1'b0;

   bist_march_ctrl #(.ADDR_W(4), .DATA_W(4), .BG(0), .STOP_ON_FAIL(1'b1)) u_dut_a (
      .clk(clk), .rst(rst), .start(a_start), .mem_rdata(a_rdata),
      .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_we(a_we), .mem_re(a_re),
      .busy(a_busy), .done(a_done), .fail(a_fail), .fail_addr(a_fail_addr),
      .fail_elem(a_fail_elem), .fail_data(a_fail_data)
   );

   always @(posedge clk) begin
      if (a_we) a_mem[a_addr] <= a_wdata;
      if (a_re) a_rdata <= a_mem[a_addr] | ((a_sa_en && a_addr == 4'd5) ? 4'b0001 : 4'b0000);
   end

   // ---------------- instance b ----------------
   logic       b_start = 1'b0;
   logic [3:0] b_rdata = 4'h0;
   logic [3:0] b_addr, b_wdata, b_fail_addr, b_fail_data;
   logic [2:0] b_fail_elem;
   logic       b_we, b_re, b_busy, b_done, b_fail;
   logic [3:0] b_mem [16];
   logic       b_cpl_en = 1'b0;

   bist_march_ctrl #(.ADDR_W(4), .DATA_W(4), .BG(1), .STOP_ON_FAIL(1'b0)) u_dut_b (
      .clk(clk), .rst(rst), .start(b_start), .mem_rdata(b_rdata),
      .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_we(b_we), .mem_re(b_re),
      .busy(b_busy), .done(b_done), .fail(b_fail), .fail_addr(b_fail_addr),
      .fail_elem(b_fail_elem), .fail_data(b_fail_data)
   );

   always @(posedge clk) begin
      if (b_we) begin
         b_mem[b_addr] <= b_wdata;
         if (b_cpl_en && b_addr == 4'd9) b_mem[3] <= ~b_mem[3];
      end
      if (b_re) b_rdata <= b_mem[b_addr];
   end

   // ---------------- monitors ----------------
   int   cyc = 0;
   int   start_cyc = 0;
   logic rec_on = 1'b0;
   logic overlap = 1'b0;
   logic [17:0] obs_q[$];
   logic [17:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Op record: {edge after start, we, re, addr, wdata (0 on reads)}
   always @(posedge clk) begin
      #1;
      if (rec_on && (a_we || a_re)) begin
         int e;
         e = cyc - start_cyc;
         obs_q.push_back({e[7:0], a_we, a_re, a_addr, a_re ? 4'h0 : a_wdata});
      end
   end

   always @(negedge clk) begin
      if ((a_we && a_re) || (b_we && b_re)) overlap = 1'b1;
   end

   // Pulse start on one instance, then wait (bounded) for done.
   // poke: edge count at which a second start is raised mid-run (-1 for none).
   task automatic run(input bit sel, input int poke, output int n,
                      output logic [5:0] first_op, output logic [13:0] snap0);
      @(negedge clk);
      if (sel) b_start = 1'b1; else a_start = 1'b1;
      @(posedge clk);
      #1;
      a_start = 1'b0;
      b_start = 1'b0;
      start_cyc = cyc;
      n = 0;
      first_op = '0;
      snap0 = sel ? {b_done, b_busy, b_fail, b_fail_addr, b_fail_elem, b_fail_data}
                  : {a_done, a_busy, a_fail, a_fail_addr, a_fail_elem, a_fail_data};
      while (!(sel ? b_done : a_done) && n < 400) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 1) first_op = sel ? {b_we, b_re, b_wdata} : {a_we, a_re, a_wdata};
         if (n == poke) begin
            if (sel) b_start = 1'b1; else a_start = 1'b1;
         end else if (n == poke + 1) begin
            a_start = 1'b0;
            b_start = 1'b0;
         end
      end
      chk(sel ? "b_run_done" : "a_run_done", sel ? b_done : a_done, 1'b1);
   endtask

   initial begin
      int n;
      int idx;
      logic [5:0]  fo;
      logic [13:0] s0;
      logic [3:0]  ad;

      for (int i = 0; i < 16; i++) begin
         a_mem[i] = 4'h0;
         b_mem[i] = 4'h0;
      end

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("a_reset_outs", {a_addr, a_wdata, a_we, a_re, a_busy, a_done, a_fail,
                           a_fail_addr, a_fail_elem, a_fail_data}, 24'h0);
      chk("b_reset_outs", {b_addr, b_wdata, b_we, b_re, b_busy, b_done, b_fail,
                           b_fail_addr, b_fail_elem, b_fail_data}, 24'h0);
      @(negedge clk);
      rst = 1'b0;

      // Expected March C- op stream for 16 words, BG=0; op k appears after edge k+1.
      idx = 0;
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < 16; i++) begin
            ad = (e == 3 || e == 4) ? 4'(15 - i) : 4'(i);
            if (e >= 1) begin
               idx++;
               exp_q.push_back({idx[7:0], 1'b0, 1'b1, ad, 4'h0});
            end
            if (e <= 4) begin
               idx++;
               exp_q.push_back({idx[7:0], 1'b1, 1'b0, ad,
                                (e == 1 || e == 3) ? 4'hF : 4'h0});
            end
         end
      end

      // 1: fault-free run with full op-order and timing check
      rec_on = 1'b1;
      run(1'b0, -1, n, fo, s0);
      rec_on = 1'b0;
      chk("ff_done_edge", n, 162);
      chk("ff_fail", a_fail, 1'b0);
      chk("ff_done_idle", {a_busy, a_we, a_re}, 3'b000);
      chk("ff_op_count", obs_q.size(), 160);
      for (int i = 0; i < 160 && i < obs_q.size(); i++)
         chk($sformatf("op%0d", i), obs_q[i], exp_q[i]);

      // 2: start pulsed while busy has no effect
      run(1'b0, 50, n, fo, s0);
      chk("busy_start_done_edge", n, 162);
      chk("busy_start_fail", a_fail, 1'b0);

      // 3: reset in the middle of a run, then a clean rerun
      @(negedge clk);
      a_start = 1'b1;
      @(posedge clk);
      #1;
      a_start = 1'b0;
      repeat (41) @(posedge clk);
      #1;
      chk("mid_busy", a_busy, 1'b1);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_outs", {a_addr, a_wdata, a_we, a_re, a_busy, a_done, a_fail,
                           a_fail_addr, a_fail_elem, a_fail_data}, 24'h0);
      @(negedge clk);
      rst = 1'b0;
      run(1'b0, -1, n, fo, s0);
      chk("rerun_done_edge", n, 162);
      chk("rerun_fail", a_fail, 1'b0);

      // 4: bit0 of addr 5 stuck at 1, abort on first mismatch (E1 read of addr 5, op 26)
      a_sa_en = 1'b1;
      run(1'b0, -1, n, fo, s0);
      chk("sa_done_edge", n, 29);
      chk("sa_fail", a_fail, 1'b1);
      chk("sa_fail_addr", a_fail_addr, 4'd5);
      chk("sa_fail_elem", a_fail_elem, 3'd1);
      chk("sa_fail_data", a_fail_data, 4'b0001);
      chk("sa_idle_port", {a_busy, a_we, a_re}, 3'b000);

      // 5: restart from DONE clears the capture registers
      a_sa_en = 1'b0;
      run(1'b0, -1, n, fo, s0);
      chk("restart_clear", s0, {1'b0, 1'b1, 12'h0});
      chk("restart_done_edge", n, 162);
      chk("restart_fail", a_fail, 1'b0);

      // 6: BG=1 fault-free; first op is a write of 4'hF
      run(1'b1, -1, n, fo, s0);
      chk("bg1_first_op", fo, {1'b1, 1'b0, 4'hF});
      chk("bg1_done_edge", n, 162);
      chk("bg1_fail", b_fail, 1'b0);

      // 7: coupling fault; first mismatch is E1 read of addr 3 returning 0 (expected F)
      b_cpl_en = 1'b1;
      run(1'b1, -1, n, fo, s0);
      chk("cpl_done_edge", n, 162);
      chk("cpl_fail", b_fail, 1'b1);
      chk("cpl_fail_addr", b_fail_addr, 4'd3);
      chk("cpl_fail_elem", b_fail_elem, 3'd1);
      chk("cpl_fail_data", b_fail_data, 4'h0);

      chk("we_re_exclusive", overlap, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
